operand2_issue_stage: RTL and testbench

//  Registered, parametrised second-operand selector for the CPU decode->ALU path.
//  Per instruction, picks input2 from rs2 data, sign-extended immediate or zero, by opcode class.

---
 rtl/operand2_issue_stage_pkg.sv | 25 ++
 rtl/operand2_issue_stage_if.sv | 32 +++
 rtl/operand2_issue_stage_skid_buf.sv | 54 +++++
 rtl/operand2_issue_stage.sv | 68 ++++++
 tb/tb_operand2_issue_stage.sv | 134 +++++++++++++
 5 files changed

// File: rtl/operand2_issue_stage_pkg.sv
// Shared types for the operand-2 issue stage: opcode class bounds, source tags, payload.
// The OPND2_FWD_EN build option (see top) is the only user of SRC_FWD.
package operand2_issue_stage_pkg;

  localparam logic [3:0] OP_ADD       = 4'h0;
  localparam logic [3:0] OP_RS2_LAST  = 4'h4;
  localparam logic [3:0] OP_IMM_FIRST = 4'h5;
  localparam logic [3:0] OP_IMM_LAST  = 4'h7;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'b00,
    SRC_RS2  = 2'b01,
    SRC_IMM  = 2'b10,
    SRC_FWD  = 2'b11
  } src_e;

  // Default-width payload; the top declares its own copy sized by its N parameter.
  localparam int OPND_W = 16;

  typedef struct packed {
    logic [OPND_W-1:0] data;
    src_e              src;
  } opnd2_t;

endpackage

// File: rtl/operand2_issue_stage_if.sv
// Decode->ALU operand-2 handshake bundle. master = upstream/ALU side, slave = issue stage.
interface operand2_issue_stage_if #(
  parameter int N       = 16,
  parameter int IMM_W   = 8,
  parameter int RADDR_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         opcode;
  logic [N-1:0]       rs2_in;
  logic [RADDR_W-1:0] rs2_addr;
  logic [IMM_W-1:0]   imm_in;
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_rd;
  logic [N-1:0]       fwd_data;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       input2;
  logic [1:0]         out_src;

  modport master (
    output in_valid, opcode, rs2_in, rs2_addr, imm_in,
           fwd_valid, fwd_rd, fwd_data, out_ready,
    input  in_ready, out_valid, input2, out_src
  );

  modport slave (
    input  in_valid, opcode, rs2_in, rs2_addr, imm_in,
           fwd_valid, fwd_rd, fwd_data, out_ready,
    output in_ready, out_valid, input2, out_src
  );
endinterface

// File: rtl/operand2_issue_stage_skid_buf.sv
// Generic 2-entry FIFO-ordered valid/ready buffer; head drives the output straight from a register.
module operand2_issue_stage_skid_buf #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic [1:0]   r_count;
  logic [1:0]   w_count_nxt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         r_in_ready;
  logic         w_push;
  logic         w_pop;

  assign w_push  = i_valid & r_in_ready;
  assign w_pop   = (r_count != 2'd0) & i_ready;
  assign o_ready = r_in_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      // Registered ready: equals (count < 2) for the cycle that follows.
      r_in_ready <= (w_count_nxt != 2'd2);
      case (r_count)
        2'd0: if (w_push) r_head <= i_data;
        2'd1: begin
          if (w_push && w_pop) r_head <= i_data;
          else if (w_push)     r_tail <= i_data;
        end
        default: if (w_pop) r_head <= r_tail;
      endcase
    end
  end
endmodule

// File: rtl/operand2_issue_stage.sv
// Registered second-operand selector (rs2 / sign-extended imm / zero) feeding a 2-entry buffer.
// Build option OPND2_FWD_EN: rs2-class opcodes take the writeback result on a rd/rs2 index match.
module operand2_issue_stage
  import operand2_issue_stage_pkg::*;
#(
  parameter int N       = 16,
  parameter int IMM_W   = 8,
  parameter int RADDR_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  operand2_issue_stage_if.slave bus
);
  typedef struct packed {
    logic [N-1:0] data;
    src_e         src;
  } opnd2_n_t;

  opnd2_n_t     w_sel;
  opnd2_n_t     w_head;
  logic [N-1:0] w_imm_ext;
  logic         w_out_valid;
  logic         w_in_ready;

  // Signed cast sign-extends from imm_in[IMM_W-1]; with IMM_W == N it is a plain copy.
  assign w_imm_ext = N'($signed(bus.imm_in));

  always_comb begin
    w_sel.data = '0;
    w_sel.src  = SRC_ZERO;
    if (bus.opcode <= OP_RS2_LAST) begin
      w_sel.data = bus.rs2_in;
      w_sel.src  = SRC_RS2;
`ifdef OPND2_FWD_EN
      if (bus.fwd_valid && (bus.fwd_rd == bus.rs2_addr)) begin
        w_sel.data = bus.fwd_data;
        w_sel.src  = SRC_FWD;
      end
`endif
    end else if (bus.opcode <= OP_IMM_LAST) begin
      w_sel.data = w_imm_ext;
      w_sel.src  = SRC_IMM;
    end
  end

`ifndef OPND2_FWD_EN
  logic w_unused_fwd;
  assign w_unused_fwd = ^{bus.fwd_valid, bus.fwd_rd, bus.fwd_data, bus.rs2_addr};
`endif

  operand2_issue_stage_skid_buf #(
    .W($bits(opnd2_n_t))
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.in_valid),
    .o_ready (w_in_ready),
    .i_data  (w_sel),
    .o_valid (w_out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_head)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.input2    = w_head.data;
  assign bus.out_src   = w_head.src;
endmodule

// File: tb/tb_operand2_issue_stage.sv
// Directed bench for operand2_issue_stage; forwarding expectations follow OPND2_FWD_EN.
module tb_operand2_issue_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand2_issue_stage_if #(.N(16), .IMM_W(8), .RADDR_W(4)) bus ();

  operand2_issue_stage #(.N(16), .IMM_W(8), .RADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [1:0] s);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, "_input2"}, {16'd0, bus.input2}, {16'd0, d});
    chk({tag, "_src"}, {30'd0, bus.out_src}, {30'd0, s});
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.opcode    = 4'h0;
    bus.rs2_in    = 16'h0;
    bus.rs2_addr  = 4'h0;
    bus.imm_in    = 8'h0;
    bus.fwd_valid = 1'b0;
    bus.fwd_rd    = 4'h0;
    bus.fwd_data  = 16'h0;
    bus.out_ready = 1'b0;

    // Reset
    tick(); tick();
    chk_out("rst", 1'b0, 16'h0000, 2'b00);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    // Streaming through with ALU always ready
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.opcode = 4'h2; bus.rs2_in = 16'h1234;
    tick(); chk_out("rs2", 1'b1, 16'h1234, 2'b01);
    bus.opcode = 4'h5; bus.imm_in = 8'hF0;
    tick(); chk_out("imm_neg", 1'b1, 16'hFFF0, 2'b10);
    bus.opcode = 4'hF;
    tick(); chk_out("zero_f", 1'b1, 16'h0000, 2'b00);
    bus.opcode = 4'h4; bus.rs2_in = 16'hAAAA;
    tick(); chk_out("rs2_edge4", 1'b1, 16'hAAAA, 2'b01);
    bus.opcode = 4'h7; bus.imm_in = 8'h7F;
    tick(); chk_out("imm_edge7", 1'b1, 16'h007F, 2'b10);
    bus.opcode = 4'h8;
    tick(); chk_out("zero_edge8", 1'b1, 16'h0000, 2'b00);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: fill both entries, third must wait, then drain in order
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.opcode = 4'h1; bus.rs2_in = 16'h1111;
    tick(); chk_out("bp1", 1'b1, 16'h1111, 2'b01);
    chk("bp1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.rs2_in = 16'h2222;
    tick();
    chk("bp2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.rs2_in = 16'h3333;
    tick(); chk_out("bp3_hold", 1'b1, 16'h1111, 2'b01);
    chk("bp3_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    tick(); chk_out("bp_drain2", 1'b1, 16'h2222, 2'b01);
    chk("bp_drain2_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick(); chk_out("bp_drain3", 1'b1, 16'h3333, 2'b01);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // Forwarding match and mismatch
    bus.in_valid  = 1'b1;
    bus.opcode    = 4'h0; bus.rs2_addr = 4'd3; bus.rs2_in = 16'h5555;
    bus.fwd_valid = 1'b1; bus.fwd_rd = 4'd3; bus.fwd_data = 16'hBEEF;
    tick();
`ifdef OPND2_FWD_EN
    chk_out("fwd_hit", 1'b1, 16'hBEEF, 2'b11);
`else
    chk_out("fwd_hit", 1'b1, 16'h5555, 2'b01);
`endif
    bus.fwd_rd = 4'd4;
    tick(); chk_out("fwd_miss", 1'b1, 16'h5555, 2'b01);
    bus.opcode = 4'h6; bus.imm_in = 8'h12; bus.fwd_rd = 4'd3;
    tick(); chk_out("fwd_imm_class", 1'b1, 16'h0012, 2'b10);
    bus.in_valid = 1'b0; bus.fwd_valid = 1'b0;
    tick();

    // Reset while holding two entries
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.opcode = 4'h3; bus.rs2_in = 16'hAAA1;
    tick();
    bus.rs2_in = 16'hAAA2;
    tick();
    chk("full_before_rst", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    tick(); chk_out("mid_rst", 1'b0, 16'h0000, 2'b00);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    tick(); chk_out("after_rst", 1'b0, 16'h0000, 2'b00);
    chk("after_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("no_stale", {31'd0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
